load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Memory-stage controller sitting directly upstream of the 64x32 data memory (registered read on posedge, write on negedge).
- Accepts one load/store request per transaction from EX over a valid/ready handshake and checks alignment and range.
- Sequences the memory's read/write strobes around its one-cycle registered read latency.
- Returns a tagged result (load data or store completion) to the write-back stage over a second valid/ready handshake.

Parameters:
- MEM_WORDS, 64, number of 32-bit words in the data memory; byte range is 0..4*MEM_WORDS-1.
- MEM_ADDR_W, 6, word-address width driven to memory; must equal log2(MEM_WORDS).
- TAG_W, 5, width of the destination/tag field carried from request to response.

Ports:
- Clock  input  1  single clock for all state.
- ResetN  input  1  synchronous, active-low reset.
- ReqValid  input  1  EX presents a request.
- ReqReady  output  1  unit can accept; high only in IDLE.
- ReqWrite  input  1  1=store, 0=load.
- ReqAddr  input  32  byte address.
- ReqWData  input  32  store data; sub-word data in low bits.
- ReqSize  input  2  0=byte, 1=half, 2=word, 3=illegal.
- ReqUnsigned  input  1  zero-extend sub-word loads.
- ReqTag  input  TAG_W  destination register number, echoed on response.
- RespValid  output  1  response held for WB.
- RespReady  input  1  WB consumes response.
- RespData  output  32  load result; 0 for stores and errors.
- RespTag  output  TAG_W  echoed ReqTag.
- RespIsLoad  output  1  echoed ~ReqWrite.
- RespErr  output  1  misaligned, out-of-range or unsupported access; no memory side effect.
- MemAddress  output  MEM_ADDR_W  word address, ReqAddr[MEM_ADDR_W+1:2].
- MemWriteData  output  32  word to write.
- MemRead  output  1  read strobe to memory.
- MemWrite  output  1  write strobe to memory.
- MemReadData  input  32  memory's registered read output.

Behaviour:
- Reset (ResetN low at posedge):
  - Resulting state: IDLE.
  - All outputs 0 except ReqReady=1.
  - Any in-flight transaction is discarded without a response.
- MemWrite = (state==WR) & ResetN, so a store whose WR cycle sees ResetN low is dropped.
- Request register: ReqAddr/WData/Size/Unsigned/Tag/Write are captured on the accept edge (ReqValid & ReqReady) and held until return to IDLE. MemAddress and MemWriteData are driven from this register.
- States and transitions:
  - IDLE: ReqReady=1. On accept:
    - error -> RESP with RespErr=1;
    - load -> RD;
    - store, word -> WR;
    - store, sub-word -> RD (read-modify-write).
  - RD: MemRead=1 for exactly one cycle; memory samples at the next edge. -> RD_DATA.
  - RD_DATA: MemRead=0. At the next edge MemReadData is valid:
    - load: lane extracted/extended into RespData -> RESP;
    - sub-word store: lane merged into MemWriteData -> WR.
  - WR: MemWrite=1 for exactly one cycle; memory writes on the mid-cycle negedge. -> RESP.
  - RESP: RespValid=1; outputs held stable while RespReady=0. On RespReady -> IDLE.
- Latency, accept edge k to RespValid visible:
  - load: after edge k+3;
  - word store: after edge k+2;
  - sub-word store: after edge k+4;
  - error: after edge k+1.
- Throughput: no overlap; the next request is accepted no earlier than the cycle after the response handshake.
- Error conditions:
  - ReqAddr >= 4*MEM_WORDS;
  - ReqSize==3;
  - half with ReqAddr[0]!=0;
  - word with ReqAddr[1:0]!=0.
- Error responses: MemRead and MemWrite never asserted; RespData=0.
- Lane selection: byte lane = ReqAddr[1:0] (lane 0 = bits 7:0); half lane = ReqAddr[1] (0 = bits 15:0). Loads sign-extend unless ReqUnsigned=1.
- ReqValid while not in IDLE is ignored (ReqReady=0). EX must hold the request stable until accepted.

Optional Feature:
- Macro: LSU_SUBWORD_EN.
- Defined: byte/half loads and stores as specified above, including read-modify-write stores.
- Undefined:
  - ReqSize 0 or 1 produces an error response;
  - ReqUnsigned is ignored;
  - RD_DATA only serves loads, and the RD_DATA->WR path is absent.

Test Plan:
- Store word: addr 0x10, data 0xDEADBEEF, RespReady=1 -> MemWrite high exactly one cycle with MemAddress=4; response RespIsLoad=0, RespErr=0, after edge k+2.
- Load word from 0x10 after the store -> MemRead one cycle; RespData=0xDEADBEEF after edge k+3, RespTag echoed.
- Sub-word (LSU_SUBWORD_EN):
  - SB 0x7F to 0x11 -> memory word 4 = 0xDEAD7FEF;
  - LB from 0x13 -> 0xFFFFFFDE;
  - LBU from 0x13 -> 0x000000DE;
  - LH from 0x12 -> 0xFFFFDEAD.
- Errors, each returning RespErr=1 after edge k+1 with no MemRead/MemWrite pulse:
  - word load at 0x12;
  - half at 0x11;
  - word at 0x100;
  - ReqSize=3.
- Backpressure: RespReady=0 for 5 cycles after a load -> RespValid/Data/Tag stable, ReqReady=0, a new ReqValid ignored; accepted the cycle after RespReady=1.
- ResetN low during RD_DATA of a load, then during WR of a store -> no response; ReqReady=1 next cycle; the store's memory word is unchanged.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store controller in front of a 64x32 data memory with a one-cycle registered read.
// Define LSU_SUBWORD_EN to enable byte/half loads and read-modify-write sub-word stores.
module load_store_unit #(
    parameter int MEM_WORDS  = 64,
    parameter int MEM_ADDR_W = 6,
    parameter int TAG_W      = 5
) (
    input  logic                  Clock,
    input  logic                  ResetN,
    input  logic                  ReqValid,
    output logic                  ReqReady,
    input  logic                  ReqWrite,
    input  logic [31:0]           ReqAddr,
    input  logic [31:0]           ReqWData,
    input  logic [1:0]            ReqSize,
    input  logic                  ReqUnsigned,
    input  logic [TAG_W-1:0]      ReqTag,
    output logic                  RespValid,
    input  logic                  RespReady,
    output logic [31:0]           RespData,
    output logic [TAG_W-1:0]      RespTag,
    output logic                  RespIsLoad,
    output logic                  RespErr,
    output logic [MEM_ADDR_W-1:0] MemAddress,
    output logic [31:0]           MemWriteData,
    output logic                  MemRead,
    output logic                  MemWrite,
    input  logic [31:0]           MemReadData
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_RD_DATA,
        S_WR,
        S_RESP
    } state_t;

    localparam logic [31:0] BYTE_LIMIT = 32'(4 * MEM_WORDS);
    localparam int          AW         = MEM_ADDR_W + 2;

    state_t                  state_q, state_d;
    logic [MEM_ADDR_W-1:0]   word_q, word_d;
    logic [31:0]             mem_wdata_q, mem_wdata_d;
    logic [TAG_W-1:0]        tag_q, tag_d;
    logic                    is_load_q, is_load_d;
    logic [31:0]             resp_data_q, resp_data_d;
    logic                    resp_err_q, resp_err_d;

    logic                    req_err;
    logic [31:0]             load_data;

`ifdef LSU_SUBWORD_EN
    logic [1:0]              lane_q, lane_d;
    logic [1:0]              size_q, size_d;
    logic                    unsigned_q, unsigned_d;
    logic [7:0]              rd_byte;
    logic [15:0]             rd_half;
    logic [31:0]             merged_data;

    always_comb begin
        rd_byte = MemReadData[{lane_q, 3'b000} +: 8];
        rd_half = MemReadData[{lane_q[1], 4'b0000} +: 16];
        unique case (size_q)
            2'd0:    load_data = unsigned_q ? {24'd0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
            2'd1:    load_data = unsigned_q ? {16'd0, rd_half} : {{16{rd_half[15]}}, rd_half};
            default: load_data = MemReadData;
        endcase
        // The store data sits in mem_wdata_q until the merged word replaces it.
        merged_data = MemReadData;
        if (size_q == 2'd0) merged_data[{lane_q, 3'b000} +: 8] = mem_wdata_q[7:0];
        else                merged_data[{lane_q[1], 4'b0000} +: 16] = mem_wdata_q[15:0];
    end
`else
    logic unused_unsigned;
    assign unused_unsigned = ReqUnsigned;
    assign load_data       = MemReadData;
`endif

    always_comb begin
        req_err = (ReqAddr >= BYTE_LIMIT);
        case (ReqSize)
`ifdef LSU_SUBWORD_EN
            2'd0:    ;
            2'd1:    if (ReqAddr[0]) req_err = 1'b1;
`else
            2'd0,
            2'd1:    req_err = 1'b1;
`endif
            2'd2:    if (ReqAddr[1:0] != 2'b00) req_err = 1'b1;
            default: req_err = 1'b1;
        endcase
    end

    // NOTE: every variable gets its hold value before the case so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        word_d      = word_q;
        mem_wdata_d = mem_wdata_q;
        tag_d       = tag_q;
        is_load_d   = is_load_q;
        resp_data_d = resp_data_q;
        resp_err_d  = resp_err_q;
`ifdef LSU_SUBWORD_EN
        lane_d      = lane_q;
        size_d      = size_q;
        unsigned_d  = unsigned_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (ReqValid) begin
                    word_d      = ReqAddr[AW-1:2];
                    mem_wdata_d = ReqWData;
                    tag_d       = ReqTag;
                    is_load_d   = ~ReqWrite;
                    resp_data_d = '0;
                    resp_err_d  = req_err;
`ifdef LSU_SUBWORD_EN
                    lane_d      = ReqAddr[1:0];
                    size_d      = ReqSize;
                    unsigned_d  = ReqUnsigned;
`endif
                    if (req_err)                          state_d = S_RESP;
                    else if (ReqWrite && ReqSize == 2'd2) state_d = S_WR;
                    else                                  state_d = S_RD;
                end
            end
            S_RD:      state_d = S_RD_DATA;
            S_RD_DATA: begin
                state_d     = S_RESP;
                resp_data_d = load_data;
`ifdef LSU_SUBWORD_EN
                if (!is_load_q) begin
                    resp_data_d = '0;
                    mem_wdata_d = merged_data;
                    state_d     = S_WR;
                end
`endif
            end
            S_WR:      state_d = S_RESP;
            S_RESP:    if (RespReady) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge Clock) begin
        if (!ResetN) begin
            state_q     <= S_IDLE;
            word_q      <= '0;
            mem_wdata_q <= '0;
            tag_q       <= '0;
            is_load_q   <= 1'b0;
            resp_data_q <= '0;
            resp_err_q  <= 1'b0;
`ifdef LSU_SUBWORD_EN
            lane_q      <= '0;
            size_q      <= '0;
            unsigned_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            word_q      <= word_d;
            mem_wdata_q <= mem_wdata_d;
            tag_q       <= tag_d;
            is_load_q   <= is_load_d;
            resp_data_q <= resp_data_d;
            resp_err_q  <= resp_err_d;
`ifdef LSU_SUBWORD_EN
            lane_q      <= lane_d;
            size_q      <= size_d;
            unsigned_q  <= unsigned_d;
`endif
        end
    end

    assign ReqReady     = (state_q == S_IDLE);
    assign RespValid    = (state_q == S_RESP);
    assign RespData     = resp_data_q;
    assign RespTag      = tag_q;
    assign RespIsLoad   = is_load_q;
    assign RespErr      = resp_err_q;
    assign MemAddress   = word_q;
    assign MemWriteData = mem_wdata_q;
    assign MemRead      = (state_q == S_RD);
    // Gating with ResetN drops a store whose write cycle coincides with reset.
    assign MemWrite     = (state_q == S_WR) & ResetN;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized and directed bench for load_store_unit against a byte-array reference model.
module tb_load_store_unit;

    localparam int MEM_WORDS  = 64;
    localparam int MEM_ADDR_W = 6;
    localparam int TAG_W      = 5;
    localparam int BYTES      = 4 * MEM_WORDS;
`ifdef LSU_SUBWORD_EN
    localparam bit SUBWORD = 1'b1;
`else
    localparam bit SUBWORD = 1'b0;
`endif
    localparam logic [31:0]      INTR_DATA = 32'h0BAD_F00D;
    localparam logic [TAG_W-1:0] INTR_TAG  = 5'd31;

    logic                  Clock = 1'b0;
    logic                  ResetN;
    logic                  ReqValid, ReqReady, ReqWrite, ReqUnsigned;
    logic [31:0]           ReqAddr, ReqWData;
    logic [1:0]            ReqSize;
    logic [TAG_W-1:0]      ReqTag;
    logic                  RespValid, RespReady, RespIsLoad, RespErr;
    logic [31:0]           RespData;
    logic [TAG_W-1:0]      RespTag;
    logic [MEM_ADDR_W-1:0] MemAddress;
    logic [31:0]           MemWriteData;
    logic                  MemRead, MemWrite;
    logic [31:0]           MemReadData = '0;

    int pass_cnt  = 0;
    int total_cnt = 0;

    load_store_unit #(.MEM_WORDS(MEM_WORDS), .MEM_ADDR_W(MEM_ADDR_W), .TAG_W(TAG_W)) dut (
        .Clock(Clock), .ResetN(ResetN),
        .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqWrite(ReqWrite), .ReqAddr(ReqAddr),
        .ReqWData(ReqWData), .ReqSize(ReqSize), .ReqUnsigned(ReqUnsigned), .ReqTag(ReqTag),
        .RespValid(RespValid), .RespReady(RespReady), .RespData(RespData), .RespTag(RespTag),
        .RespIsLoad(RespIsLoad), .RespErr(RespErr),
        .MemAddress(MemAddress), .MemWriteData(MemWriteData), .MemRead(MemRead),
        .MemWrite(MemWrite), .MemReadData(MemReadData)
    );

    always #5 Clock = ~Clock;

    // Reference model: flat little-endian byte array.
    logic [7:0] ref_mem [BYTES];

    function automatic logic [31:0] ref_word(input int w);
        return {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]};
    endfunction

    function automatic logic ref_err(input logic [31:0] addr, input logic [1:0] size);
        int nbytes;
        if (addr >= 32'(BYTES)) return 1'b1;
        if (size == 2'd3) return 1'b1;
        if (!SUBWORD && size != 2'd2) return 1'b1;
        nbytes = 1 << size;
        return (int'(addr) % nbytes) != 0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] addr, input logic [1:0] size,
                                             input logic uns);
        int     nbytes;
        longint val;
        nbytes = 1 << size;
        val    = 0;
        for (int i = 0; i < nbytes; i++) val += longint'(ref_mem[int'(addr) + i]) << (8 * i);
        if (!uns && nbytes < 4 && val >= (longint'(1) << (8 * nbytes - 1)))
            val -= longint'(1) << (8 * nbytes);
        return 32'(val);
    endfunction

    task automatic ref_store(input logic [31:0] addr, input logic [31:0] wdata, input logic [1:0] size);
        int nbytes;
        nbytes = 1 << size;
        for (int i = 0; i < nbytes; i++) ref_mem[int'(addr) + i] = 8'(wdata >> (8 * i));
    endtask

    // Data memory: registered read on posedge, write on negedge.
    logic [31:0] mem [MEM_WORDS];
    logic        load_mem = 1'b0;

    always @(negedge Clock) begin
        if (load_mem) for (int w = 0; w < MEM_WORDS; w++) mem[w] <= ref_word(w);
        else if (MemWrite) mem[MemAddress] <= MemWriteData;
    end

    always @(posedge Clock) if (MemRead) MemReadData <= mem[MemAddress];

    int                    rd_total = 0;
    int                    wr_total = 0;
    logic [MEM_ADDR_W-1:0] wr_addr_last = '0;
    logic [31:0]           wr_data_last = '0;

    always @(negedge Clock) begin
        if (MemRead) rd_total++;
        if (MemWrite) begin
            wr_total++;
            wr_addr_last = MemAddress;
            wr_data_last = MemWriteData;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1);
    end

    // One full transaction, every observation compared with the reference model.
    task automatic scored_txn(input string name, input logic wr, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [1:0] size, input logic uns,
                              input logic [TAG_W-1:0] tag, input int hold, input logic intrude,
                              output logic [31:0] got);
        logic             exp_err, e0, l0, stable, blocked;
        logic [31:0]      exp_data, exp_word, d0;
        logic [TAG_W-1:0] t0;
        int               exp_lat, exp_rd, exp_wr, rd0, wr0, waits, lat;

        exp_err  = ref_err(addr, size);
        exp_data = '0;
        if (exp_err) begin
            exp_lat = 1; exp_rd = 0; exp_wr = 0;
        end else if (!wr) begin
            exp_data = ref_load(addr, size, uns);
            exp_lat = 3; exp_rd = 1; exp_wr = 0;
        end else if (size == 2'd2) begin
            exp_lat = 2; exp_rd = 0; exp_wr = 1;
        end else begin
            exp_lat = 4; exp_rd = 1; exp_wr = 1;
        end
        if (wr && !exp_err) ref_store(addr, wdata, size);
        exp_word = ref_word(int'(addr[7:2]));

        rd0 = rd_total; wr0 = wr_total;
        ReqValid = 1'b1; ReqWrite = wr; ReqAddr = addr; ReqWData = wdata;
        ReqSize = size; ReqUnsigned = uns; ReqTag = tag; RespReady = 1'b0;
        waits = 0;
        while (!ReqReady && waits < 8) begin @(posedge Clock); #1; waits++; end
        @(posedge Clock); #1;
        ReqValid = 1'b0; ReqWrite = 1'($urandom); ReqAddr = $urandom; ReqWData = $urandom;
        ReqSize = 2'($urandom); ReqUnsigned = 1'($urandom); ReqTag = TAG_W'($urandom);
        lat = 1;
        while (!RespValid && lat < 12) begin @(posedge Clock); #1; lat++; end
        got = RespData; d0 = RespData; e0 = RespErr; l0 = RespIsLoad; t0 = RespTag;

        stable = 1'b1; blocked = 1'b1;
        if (intrude) begin
            ReqValid = 1'b1; ReqWrite = 1'b1; ReqAddr = 32'h20; ReqWData = INTR_DATA;
            ReqSize = 2'd2; ReqUnsigned = 1'b0; ReqTag = INTR_TAG;
        end
        for (int i = 0; i < hold; i++) begin
            @(posedge Clock); #1;
            if (RespValid !== 1'b1 || RespData !== d0 || RespErr !== e0 || RespIsLoad !== l0 ||
                RespTag !== t0) stable = 1'b0;
            if (ReqReady !== 1'b0) blocked = 1'b0;
        end
        RespReady = 1'b1;
        @(posedge Clock); #1;
        RespReady = 1'b0;

        total_cnt++; if (waits !== 0) $display("FAIL %s accept: waited %0d cycles, required 0", name, waits); else pass_cnt++;
        total_cnt++; if (lat !== exp_lat) $display("FAIL %s latency: got %0d edges, required %0d", name, lat, exp_lat); else pass_cnt++;
        total_cnt++; if (e0 !== exp_err) $display("FAIL %s RespErr: got %b required %b", name, e0, exp_err); else pass_cnt++;
        total_cnt++; if (d0 !== exp_data) $display("FAIL %s RespData: got %h required %h", name, d0, exp_data); else pass_cnt++;
        total_cnt++; if (t0 !== tag) $display("FAIL %s RespTag: got %0d required %0d", name, t0, tag); else pass_cnt++;
        total_cnt++; if (l0 !== ~wr) $display("FAIL %s RespIsLoad: got %b required %b", name, l0, ~wr); else pass_cnt++;
        total_cnt++; if (rd_total - rd0 !== exp_rd) $display("FAIL %s MemRead cycles: got %0d required %0d", name, rd_total - rd0, exp_rd); else pass_cnt++;
        total_cnt++; if (wr_total - wr0 !== exp_wr) $display("FAIL %s MemWrite cycles: got %0d required %0d", name, wr_total - wr0, exp_wr); else pass_cnt++;
        if (exp_wr == 1) begin
            total_cnt++; if (wr_addr_last !== addr[7:2]) $display("FAIL %s MemAddress: got %0d required %0d", name, wr_addr_last, addr[7:2]); else pass_cnt++;
            total_cnt++; if (wr_data_last !== exp_word) $display("FAIL %s MemWriteData: got %h required %h", name, wr_data_last, exp_word); else pass_cnt++;
        end
        if (hold > 0) begin
            total_cnt++; if (stable !== 1'b1) $display("FAIL %s response stability: got %b required 1", name, stable); else pass_cnt++;
            total_cnt++; if (blocked !== 1'b1) $display("FAIL %s ReqReady low while busy: got %b required 1", name, blocked); else pass_cnt++;
        end
        total_cnt++; if ({RespValid, ReqReady} !== 2'b01) $display("FAIL %s after handshake {RespValid,ReqReady}: got %b required 01", name, {RespValid, ReqReady}); else pass_cnt++;
    endtask

    task automatic test_reset();
        ResetN = 1'b0; ReqValid = 1'b0; ReqWrite = 1'b0; ReqAddr = '0; ReqWData = '0;
        ReqSize = '0; ReqUnsigned = 1'b0; ReqTag = '0; RespReady = 1'b0;
        repeat (3) @(posedge Clock);
        #1;
        load_mem = 1'b0;
        total_cnt++; if ({ReqReady, RespValid, RespIsLoad, RespErr, MemRead, MemWrite} !== 6'b100000) $display("FAIL reset flags: got %b required 100000", {ReqReady, RespValid, RespIsLoad, RespErr, MemRead, MemWrite}); else pass_cnt++;
        total_cnt++; if (RespData !== 32'd0 || RespTag !== '0) $display("FAIL reset response: got data %h tag %0d required 0", RespData, RespTag); else pass_cnt++;
        total_cnt++; if (MemAddress !== '0 || MemWriteData !== 32'd0) $display("FAIL reset memory bus: got addr %0d data %h required 0", MemAddress, MemWriteData); else pass_cnt++;
        ResetN = 1'b1;
        @(posedge Clock); #1;
    endtask

    task automatic test_word_access();
        logic [31:0] got;
        scored_txn("sw_0x10", 1'b1, 32'h10, 32'hDEADBEEF, 2'd2, 1'b0, 5'd3, 0, 1'b0, got);
        total_cnt++; if (mem[4] !== 32'hDEADBEEF) $display("FAIL sw_0x10 memory word 4: got %h required deadbeef", mem[4]); else pass_cnt++;
        scored_txn("lw_0x10", 1'b0, 32'h10, 32'd0, 2'd2, 1'b0, 5'd7, 0, 1'b0, got);
        total_cnt++; if (got !== 32'hDEADBEEF) $display("FAIL lw_0x10 value: got %h required deadbeef", got); else pass_cnt++;
    endtask

    task automatic test_subword();
        logic [31:0] got;
        scored_txn("sb_0x11", 1'b1, 32'h11, 32'hAAAA_AA7F, 2'd0, 1'b0, 5'd4, 0, 1'b0, got);
`ifdef LSU_SUBWORD_EN
        total_cnt++; if (mem[4] !== 32'hDEAD7FEF) $display("FAIL sb_0x11 memory word 4: got %h required dead7fef", mem[4]); else pass_cnt++;
        scored_txn("lb_0x13", 1'b0, 32'h13, 32'd0, 2'd0, 1'b0, 5'd5, 0, 1'b0, got);
        total_cnt++; if (got !== 32'hFFFFFFDE) $display("FAIL lb_0x13 value: got %h required ffffffde", got); else pass_cnt++;
        scored_txn("lbu_0x13", 1'b0, 32'h13, 32'd0, 2'd0, 1'b1, 5'd6, 0, 1'b0, got);
        total_cnt++; if (got !== 32'h000000DE) $display("FAIL lbu_0x13 value: got %h required 000000de", got); else pass_cnt++;
        scored_txn("lh_0x12", 1'b0, 32'h12, 32'd0, 2'd1, 1'b0, 5'd8, 0, 1'b0, got);
        total_cnt++; if (got !== 32'hFFFFDEAD) $display("FAIL lh_0x12 value: got %h required ffffdead", got); else pass_cnt++;
`else
        total_cnt++; if (mem[4] !== 32'hDEADBEEF) $display("FAIL sb_0x11 memory word 4: got %h required deadbeef", mem[4]); else pass_cnt++;
        scored_txn("lh_0x12", 1'b0, 32'h12, 32'd0, 2'd1, 1'b0, 5'd8, 0, 1'b0, got);
`endif
    endtask

    task automatic test_errors();
        logic [31:0] got;
        scored_txn("err_lw_0x12", 1'b0, 32'h12, 32'd0, 2'd2, 1'b0, 5'd10, 0, 1'b0, got);
        scored_txn("err_lh_0x11", 1'b0, 32'h11, 32'd0, 2'd1, 1'b0, 5'd11, 0, 1'b0, got);
        scored_txn("err_sw_0x100", 1'b1, 32'h100, 32'h1234_5678, 2'd2, 1'b0, 5'd12, 0, 1'b0, got);
        scored_txn("err_size3", 1'b1, 32'h0, 32'h1234_5678, 2'd3, 1'b0, 5'd13, 0, 1'b0, got);
    endtask

    task automatic test_backpressure();
        logic [31:0] got;
        scored_txn("bp_load", 1'b0, 32'h10, 32'd0, 2'd2, 1'b0, 5'd9, 5, 1'b1, got);
        scored_txn("bp_next", 1'b1, 32'h20, INTR_DATA, 2'd2, 1'b0, INTR_TAG, 0, 1'b0, got);
    endtask

    task automatic test_reset_midflight();
        int   wr0;
        logic seen;
        ReqValid = 1'b1; ReqWrite = 1'b0; ReqAddr = 32'h10; ReqSize = 2'd2; ReqTag = 5'd2;
        @(posedge Clock); #1;
        ReqValid = 1'b0;
        @(posedge Clock); #1;
        ResetN = 1'b0;
        @(posedge Clock); #1;
        ResetN = 1'b1;
        total_cnt++; if ({ReqReady, RespValid} !== 2'b10) $display("FAIL rst_load {ReqReady,RespValid}: got %b required 10", {ReqReady, RespValid}); else pass_cnt++;
        seen = 1'b0;
        repeat (3) begin @(posedge Clock); #1; if (RespValid) seen = 1'b1; end
        total_cnt++; if (seen !== 1'b0) $display("FAIL rst_load stray response: got %b required 0", seen); else pass_cnt++;

        wr0 = wr_total;
        ReqValid = 1'b1; ReqWrite = 1'b1; ReqAddr = 32'h24; ReqWData = ~ref_word(9);
        ReqSize = 2'd2; ReqTag = 5'd1;
        @(posedge Clock); #1;
        ReqValid = 1'b0;
        ResetN = 1'b0;
        @(posedge Clock); #1;
        ResetN = 1'b1;
        total_cnt++; if ({ReqReady, RespValid} !== 2'b10) $display("FAIL rst_store {ReqReady,RespValid}: got %b required 10", {ReqReady, RespValid}); else pass_cnt++;
        total_cnt++; if (wr_total !== wr0) $display("FAIL rst_store MemWrite cycles: got %0d required 0", wr_total - wr0); else pass_cnt++;
        total_cnt++; if (mem[9] !== ref_word(9)) $display("FAIL rst_store memory word 9: got %h required %h", mem[9], ref_word(9)); else pass_cnt++;
    endtask

    task automatic test_random();
        logic [31:0]      addr, wdata, got;
        logic [1:0]       size;
        logic             wr, uns;
        logic [TAG_W-1:0] tag;
        int               hold;
        for (int n = 0; n < 40; n++) begin
            size  = 2'($urandom_range(0, 3));
            addr  = 32'($urandom_range(0, BYTES + 15));
            if (size != 2'd3 && $urandom_range(0, 3) != 0) addr = addr & ~((32'd1 << size) - 32'd1);
            wr    = 1'($urandom_range(0, 1));
            uns   = 1'($urandom_range(0, 1));
            wdata = $urandom;
            tag   = TAG_W'($urandom);
            hold  = int'($urandom_range(0, 2));
            scored_txn($sformatf("rnd%0d", n), wr, addr, wdata, size, uns, tag, hold, 1'b0, got);
        end
    endtask

    task automatic test_final_memory();
        int bad, first;
        bad = 0; first = -1;
        for (int w = 0; w < MEM_WORDS; w++) begin
            if (mem[w] !== ref_word(w)) begin
                bad++;
                if (first < 0) first = w;
            end
        end
        total_cnt++; if (bad !== 0) $display("FAIL final memory: %0d words differ, first word %0d got %h required %h", bad, first, mem[first], ref_word(first)); else pass_cnt++;
    endtask

    initial begin
        ResetN = 1'b0;
        for (int i = 0; i < BYTES; i++) ref_mem[i] = 8'($urandom);
        load_mem = 1'b1;
        test_reset();
        test_word_access();
        test_subword();
        test_errors();
        test_backpressure();
        test_reset_midflight();
        test_random();
        test_final_memory();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
